// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the pipeline stage registers: occupancy encoding,
// per-stage payload structs and the bubble control words each stage loads
// when it is empty or flushed.
package pipe_stage_reg_pkg;

  // Entry count held by a stage register; the value doubles as the
  // occupancy port encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } pipe_occ_t;

  // decode -> execute payloads (64-bit data, 16-bit control)
  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] imm;
  } execute_data_t;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       rf_we;
    logic       dmem_we;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_wb;
    logic [1:0] mem_size;
    logic       dmem_re;
    logic       branch;
  } execute_ctrl_t;

  // execute -> memory payloads (64-bit data, 16-bit control)
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
  } memory_data_t;

  typedef struct packed {
    logic       rf_we;
    logic       dmem_we;
    logic       dmem_re;
    logic [1:0] mem_size;
    logic [1:0] sel_wb;
    logic [4:0] rd;
    logic [3:0] rsvd;
  } memory_ctrl_t;

  // Bubble words: every write enable low so an empty stage is a no-op.
  localparam execute_ctrl_t EXECUTE_BUBBLE_CTRL = '0;

  localparam memory_ctrl_t MEMORY_BUBBLE_CTRL = '{
    rf_we:    1'b0,
    dmem_we:  1'b0,
    dmem_re:  1'b0,
    mem_size: 2'b10,
    sel_wb:   2'b01,
    rd:       5'd0,
    rsvd:     4'd0
  };

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up on inc until all-ones, then hold; clear has priority.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer,
// stall/flush control and a saturating bubble counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(0),
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_occ_t         occ_q, occ_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire;

  // Handshake: reset_n gates in_ready so nothing is accepted while the
  // stage is held in reset.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready = reset_n & (occ_q != OCC_TWO) & ~stall & ~flush;
    end else begin : g_ready_noskid
      assign in_ready = reset_n & ((occ_q == OCC_EMPTY) | out_ready) & ~stall & ~flush;
    end
  endgenerate

  assign out_valid = (occ_q != OCC_EMPTY) & ~stall & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Empty stage presents a clean bubble rather than stale main contents.
  assign out_data  = (occ_q == OCC_EMPTY) ? '0 : main_data_q;
  assign out_ctrl  = (occ_q == OCC_EMPTY) ? BUBBLE_CTRL : main_ctrl_q;
  assign occupancy = occ_q;

  // Next occupancy and entry contents; flush overrides every transfer.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path
    // leaves a value unassigned and a latch cannot be inferred.
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      occ_d       = OCC_EMPTY;
      main_data_d = '0;
      main_ctrl_d = BUBBLE_CTRL;
      skid_data_d = '0;
      skid_ctrl_d = BUBBLE_CTRL;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ_d       = OCC_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire && (SKID != 0)) begin
            occ_d       = OCC_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only the drain path exists; the skid
          // entry moves up to keep FIFO order.
          if (out_fire) begin
            occ_d       = OCC_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy and main entry registers.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: payload storage is reset too, so contents vanish immediately
    // on reset and the empty-stage bubble value is well defined.
    if (!reset_n) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  // Skid entry exists only in the 2-entry configuration.
  generate
    if (SKID != 0) begin : g_skid
      // Skid entry register, loaded on overflow and cleared on flush.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          skid_data_q <= '0;
          skid_ctrl_q <= BUBBLE_CTRL;
        end else begin
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
        end
      end
    end else begin : g_noskid
      assign skid_data_q = '0;
      assign skid_ctrl_q = BUBBLE_CTRL;
    end
  endgenerate

  // Bubble counter: cycles where downstream could take data but none is
  // offered; never cleared except by reset.
  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (out_ready & ~out_valid),
    .clear   (1'b0),
    .count   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: u0 is the skid configuration with a
// 4-bit bubble counter, u1 the single-entry configuration on shared inputs.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [15:0] BUB = MEMORY_BUBBLE_CTRL;

  logic        clock = 1'b0;
  logic        reset_n, stall, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [3:0]  bubble_cnt;

  logic        in_ready_n, out_valid_n;
  logic [63:0] out_data_n;
  logic [15:0] out_ctrl_n;
  logic [1:0]  occupancy_n;
  logic [3:0]  bubble_cnt_n;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID(1), .CNT_W(4)) u0 (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID(0), .CNT_W(4)) u1 (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_ctrl(out_ctrl_n),
    .occupancy(occupancy_n), .bubble_cnt(bubble_cnt_n)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 16'h1234;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_ctrl !== BUB) $display("FAIL reset_out_ctrl: got %h want %h", out_ctrl, BUB); else passed++;
    total++; if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else passed++;
    total++; if (bubble_cnt !== 4'd0) $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (in_ready_n !== 1'b1) $display("FAIL release_in_ready_noskid: got %b want 1", in_ready_n); else passed++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'd1; in_ctrl = 16'd1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (out_data !== 64'(i) || out_ctrl !== 16'(i) || out_valid !== 1'b1 || occupancy !== 2'd1)
        $display("FAIL stream_beat%0d: got data %h ctrl %h valid %b occ %0d want data %h ctrl %h valid 1 occ 1",
                 i, out_data, out_ctrl, out_valid, occupancy, 64'(i), 16'(i));
      else passed++;
      total++; if (out_data_n !== 64'(i) || occupancy_n !== 2'd1)
        $display("FAIL stream_noskid_beat%0d: got data %h occ %0d want data %h occ 1", i, out_data_n, occupancy_n, 64'(i));
      else passed++;
      if (i < 8) begin
        in_data = 64'(i + 1); in_ctrl = 16'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    total++; if (occupancy !== 2'd0 || out_data !== 64'h0 || out_ctrl !== BUB || out_valid !== 1'b0)
      $display("FAIL stream_drain: got occ %0d data %h ctrl %h valid %b want occ 0 data 0 ctrl %h valid 0",
               occupancy, out_data, out_ctrl, out_valid, BUB);
    else passed++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'hA;
    tick();
    in_data = 64'hB; in_ctrl = 16'hB;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_in_one: got %b want 1", in_ready); else passed++;
    tick();
    in_data = 64'hC; in_ctrl = 16'hC;
    #1;
    total++; if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 64'hA)
      $display("FAIL bp_two: got ready %b occ %0d data %h want ready 0 occ 2 data a", in_ready, occupancy, out_data);
    else passed++;
    tick();
    total++; if (occupancy !== 2'd2 || out_data !== 64'hA || out_valid !== 1'b1)
      $display("FAIL bp_hold: got occ %0d data %h valid %b want occ 2 data a valid 1", occupancy, out_data, out_valid);
    else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 64'hB || occupancy !== 2'd1 || in_ready !== 1'b1)
      $display("FAIL bp_drain_b: got data %h occ %0d ready %b want data b occ 1 ready 1", out_data, occupancy, in_ready);
    else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 64'hC || out_ctrl !== 16'hC || occupancy !== 2'd1)
      $display("FAIL bp_drain_c: got data %h ctrl %h occ %0d want data c ctrl c occ 1", out_data, out_ctrl, occupancy);
    else passed++;
    tick();
    total++; if (occupancy !== 2'd0) $display("FAIL bp_empty: got occ %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 16'h11;
    tick();
    in_data = 64'h22; in_ctrl = 16'h22;
    tick();
    in_data = 64'h33; in_ctrl = 16'h33; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL flush_comb: got ready %b valid %b want 0 0", in_ready, out_valid);
    else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== BUB || out_data !== 64'h0)
      $display("FAIL flush_empty: got occ %0d valid %b ctrl %h data %h want occ 0 valid 0 ctrl %h data 0",
               occupancy, out_valid, out_ctrl, out_data, BUB);
    else passed++;
    out_ready = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0 || occupancy_n !== 2'd0)
      $display("FAIL flush_dropped: got valid %b occ_noskid %0d want 0 0", out_valid, occupancy_n);
    else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h5; in_ctrl = 16'h5;
    tick();
    in_data = 64'h6; in_ctrl = 16'h6;
    stall = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL stall_comb: got valid %b ready %b want 0 0", out_valid, in_ready);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (occupancy !== 2'd1 || out_valid !== 1'b0 || out_data !== 64'h5)
        $display("FAIL stall_hold%0d: got occ %0d valid %b data %h want occ 1 valid 0 data 5", i, occupancy, out_valid, out_data);
      else passed++;
    end
    stall = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'h5)
      $display("FAIL stall_release: got valid %b data %h want 1 5", out_valid, out_data);
    else passed++;
    tick();
    total++; if (occupancy !== 2'd0) $display("FAIL stall_drain: got occ %0d want 0", occupancy); else passed++;
    // Flush and stall together: flush must still empty the stage.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h7; in_ctrl = 16'h7;
    tick();
    in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    #1;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || occupancy_n !== 2'd0)
      $display("FAIL flush_over_stall: got occ %0d valid %b occ_noskid %0d want 0 0 0", occupancy, out_valid, occupancy_n);
    else passed++;
  endtask

  task automatic test_noskid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h9; in_ctrl = 16'h9;
    #1;
    total++; if (in_ready_n !== 1'b1) $display("FAIL noskid_ready_empty: got %b want 1", in_ready_n); else passed++;
    tick();
    total++; if (in_ready_n !== 1'b0 || occupancy_n !== 2'd1)
      $display("FAIL noskid_ready_blocked: got ready %b occ %0d want 0 1", in_ready_n, occupancy_n);
    else passed++;
    out_ready = 1'b1; in_data = 64'hA; in_ctrl = 16'hA;
    #1;
    total++; if (in_ready_n !== 1'b1) $display("FAIL noskid_ready_comb: got %b want 1", in_ready_n); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_data_n !== 64'hA || occupancy_n !== 2'd1)
      $display("FAIL noskid_passthru: got data %h occ %0d want a 1", out_data_n, occupancy_n);
    else passed++;
    tick();
    total++; if (occupancy_n !== 2'd0 || occupancy !== 2'd0)
      $display("FAIL noskid_empty: got occ_noskid %0d occ %0d want 0 0", occupancy_n, occupancy);
    else passed++;
  endtask

  task automatic test_counter();
    out_ready = 1'b0; in_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    total++; if (bubble_cnt !== 4'd0) $display("FAIL cnt_idle: got %0d want 0", bubble_cnt); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (bubble_cnt !== 4'd5) $display("FAIL cnt_five: got %0d want 5", bubble_cnt); else passed++;
    for (int i = 0; i < 15; i++) tick();
    total++; if (bubble_cnt !== 4'd15) $display("FAIL cnt_sat: got %0d want 15", bubble_cnt); else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++; if (bubble_cnt !== 4'd15) $display("FAIL cnt_hold: got %0d want 15", bubble_cnt); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_stall();
    test_noskid();
    test_counter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
